// File: rtl/rtc_timer.sv
// rtc_timer: RISC-V machine timer (mtime / mtimecmp) on the hart data bus.
// Word map: 0x0 mtime lo, 0x4 mtime hi, 0x8 mtimecmp lo, 0xC mtimecmp hi.
// Read data is registered and driven for exactly one cycle, high-Z otherwise,
// because the read-data bus is shared with the RAM.
// Optional feature macro: RTC_TIMER_EDGE_DETECT_EN -- when defined, rtc is a raw
// asynchronous level; it is synchronized and every edge (rising or falling)
// produces one tick. When undefined, rtc is a synchronous one-cycle tick pulse.
module rtc_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        rtc,
   input  logic        chip_select,
   input  logic [3:0]  addr,
   input  logic        op,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        interrupt
);

   localparam logic [1:0] W_MTIME_LO = 2'd0;
   localparam logic [1:0] W_MTIME_HI = 2'd1;
   localparam logic [1:0] W_CMP_LO   = 2'd2;
   localparam logic [1:0] W_CMP_HI   = 2'd3;

   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        irq_q, irq_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic        tick_s;
   logic        wr_s;
   logic        rd_s;
   logic [1:0]  word_s;

`ifdef RTC_TIMER_EDGE_DETECT_EN
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic dly_q, dly_d;

   // Synchronizer chain plus delay flop; any change between the last two is an edge.
   always_comb begin
      sync1_d = rtc;
      sync2_d = sync1_q;
      dly_d   = sync2_q;
      tick_s  = sync2_q ^ dly_q;
   end

   // Synchronizer and edge-delay registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         dly_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         dly_q   <= dly_d;
      end
   end
`else
   // rtc is already a synchronous pulse; each high cycle is one tick.
   always_comb begin
      tick_s = rtc;
   end
`endif

   // Bus decode, register update, read mux and compare for the next state.
   always_comb begin
      wr_s       = chip_select & op;
      rd_s       = chip_select & ~op;
      word_s     = addr[3:2];
      mtime_d    = mtime_q;
      mtimecmp_d = mtimecmp_q;
      rvalid_d   = rd_s;
      rdata_d    = rdata_q;
      irq_d      = (mtime_q >= mtimecmp_q);

      // A write to either mtime word overrides the tick for that cycle, so the
      // untouched word neither increments nor receives a carry.
      if (wr_s && (word_s == W_MTIME_LO)) begin
         mtime_d = {mtime_q[63:32], data_i};
      end else if (wr_s && (word_s == W_MTIME_HI)) begin
         mtime_d = {data_i, mtime_q[31:0]};
      end else if (tick_s) begin
         mtime_d = mtime_q + 64'd1;
      end else begin
         mtime_d = mtime_q;
      end

      if (wr_s) begin
         case (word_s)
            W_CMP_LO: mtimecmp_d = {mtimecmp_q[63:32], data_i};
            W_CMP_HI: mtimecmp_d = {data_i, mtimecmp_q[31:0]};
            default:  mtimecmp_d = mtimecmp_q;
         endcase
      end else begin
         mtimecmp_d = mtimecmp_q;
      end

      // Reads return the pre-increment value present at the request edge.
      if (rd_s) begin
         case (word_s)
            W_MTIME_LO: rdata_d = mtime_q[31:0];
            W_MTIME_HI: rdata_d = mtime_q[63:32];
            W_CMP_LO:   rdata_d = mtimecmp_q[31:0];
            W_CMP_HI:   rdata_d = mtimecmp_q[63:32];
            default:    rdata_d = 32'd0;
         endcase
      end else begin
         rdata_d = rdata_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mtime_q    <= 64'd0;
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
         irq_q      <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= 32'd0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         irq_q      <= irq_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

   assign interrupt = irq_q;
   assign data_o    = rvalid_q ? rdata_q : 32'bz;

endmodule

// File: tb/tb_rtc_timer.sv
// Self-checking bench for rtc_timer (default build: rtc is a one-cycle pulse).
// Vector table drives one bus cycle per row; read expectations go into a
// scoreboard queue and are popped when data_o is driven the following cycle.
module tb_rtc_timer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rtc = 1'b0;
   logic        chip_select = 1'b0;
   logic [3:0]  addr = 4'd0;
   logic        op = 1'b0;
   logic [31:0] data_i = 32'd0;
   logic [31:0] data_o;
   logic        interrupt;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic        rd_pend = 1'b0;

   typedef struct {
      logic        cs;
      logic        op;
      logic [3:0]  addr;
      logic [31:0] data;
      logic        tick;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t tbl[36];

   rtc_timer dut (
      .clk(clk), .rst(rst), .rtc(rtc), .chip_select(chip_select),
      .addr(addr), .op(op), .data_i(data_i), .data_o(data_o),
      .interrupt(interrupt)
   );

   always #5 clk = ~clk;

   // Remember whether the last edge accepted a read request.
   always @(posedge clk) rd_pend <= chip_select && !op && rst;

   // Scoreboard: data_o must carry the queued word after a read, else high-Z.
   always @(negedge clk) begin
      if (rd_pend) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected got %h expected no read", data_o);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (data_o !== e) begin
               errors++;
               $display("FAIL rd_data got %h expected %h at %0t", data_o, e, $time);
            end
         end
      end else begin
         checks++;
         if (data_o !== 32'bz) begin
            errors++;
            $display("FAIL idle_z got %h expected zzzzzzzz at %0t", data_o, $time);
         end
      end
   end

   function automatic vec_t rd(input logic [3:0] a, input logic [31:0] e, input logic irq);
      vec_t v;
      v = '{cs: 1'b1, op: 1'b0, addr: a, data: 32'd0, tick: 1'b0, exp_rd: e, exp_irq: irq};
      return v;
   endfunction

   function automatic vec_t wr(input logic [3:0] a, input logic [31:0] d, input logic t, input logic irq);
      vec_t v;
      v = '{cs: 1'b1, op: 1'b1, addr: a, data: d, tick: t, exp_rd: 32'd0, exp_irq: irq};
      return v;
   endfunction

   function automatic vec_t idle(input logic t, input logic irq);
      vec_t v;
      v = '{cs: 1'b0, op: 1'b0, addr: 4'd0, data: 32'd0, tick: t, exp_rd: 32'd0, exp_irq: irq};
      return v;
   endfunction

   // Apply one bus cycle; returns just after the clock edge that consumed it.
   task automatic drive(input vec_t v, input logic rst_v);
      rst         = rst_v;
      chip_select = v.cs;
      op          = v.op;
      addr        = v.addr;
      data_i      = v.data;
      rtc         = v.tick;
      if (v.cs && !v.op && rst_v) exp_q.push_back(v.exp_rd);
      @(posedge clk);
      #1;
   endtask

   task automatic check_irq(input string name, input logic e);
      checks++;
      if (interrupt !== e) begin
         errors++;
         $display("FAIL %s interrupt got %b expected %b", name, interrupt, e);
      end
   endtask

   initial begin
      // exp_irq: interrupt seen just after each row's edge, i.e. the compare
      // of the register values present before that edge.
      tbl[0]  = rd(4'h0, 32'h0000_0000, 1'b0);
      tbl[1]  = rd(4'h4, 32'h0000_0000, 1'b0);
      tbl[2]  = rd(4'h8, 32'hFFFF_FFFF, 1'b0);
      tbl[3]  = rd(4'hC, 32'hFFFF_FFFF, 1'b0);
      tbl[4]  = idle(1'b0, 1'b0);
      tbl[5]  = wr(4'h0, 32'hFFFF_FFFE, 1'b0, 1'b0);
      tbl[6]  = idle(1'b1, 1'b0);
      tbl[7]  = idle(1'b1, 1'b0);
      tbl[8]  = idle(1'b1, 1'b0);
      tbl[9]  = rd(4'h0, 32'h0000_0001, 1'b0);
      tbl[10] = rd(4'h4, 32'h0000_0001, 1'b0);
      tbl[11] = wr(4'h4, 32'h0000_0000, 1'b0, 1'b0);
      tbl[12] = wr(4'h0, 32'h0000_0000, 1'b0, 1'b0);
      tbl[13] = wr(4'hC, 32'h0000_0000, 1'b0, 1'b0);
      tbl[14] = wr(4'h8, 32'h0000_0005, 1'b0, 1'b0);
      tbl[15] = idle(1'b1, 1'b0);
      tbl[16] = idle(1'b1, 1'b0);
      tbl[17] = idle(1'b1, 1'b0);
      tbl[18] = idle(1'b1, 1'b0);
      tbl[19] = idle(1'b1, 1'b0);
      tbl[20] = idle(1'b0, 1'b1);
      tbl[21] = wr(4'h8, 32'd100, 1'b0, 1'b1);
      tbl[22] = idle(1'b0, 1'b0);
      tbl[23] = wr(4'h0, 32'h0000_1234, 1'b1, 1'b0);
      tbl[24] = rd(4'h0, 32'h0000_1234, 1'b1);
      tbl[25] = rd(4'h4, 32'h0000_0000, 1'b1);
      tbl[26] = wr(4'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);
      tbl[27] = wr(4'h4, 32'hFFFF_FFFF, 1'b0, 1'b1);
      tbl[28] = idle(1'b1, 1'b1);
      tbl[29] = rd(4'h0, 32'h0000_0000, 1'b0);
      tbl[30] = rd(4'h4, 32'h0000_0000, 1'b0);
      tbl[31] = idle(1'b1, 1'b0);
      tbl[32] = idle(1'b1, 1'b0);
      tbl[33] = idle(1'b1, 1'b0);
      tbl[34] = rd(4'h0, 32'h0000_0003, 1'b0);
      tbl[35] = rd(4'h4, 32'h0000_0000, 1'b0);

      // Reset for two edges.
      drive(idle(1'b0, 1'b0), 1'b0);
      drive(idle(1'b0, 1'b0), 1'b0);
      check_irq("reset", 1'b0);

      for (int i = 0; i < 36; i++) begin
         drive(tbl[i], 1'b1);
         check_irq($sformatf("row%0d", i), tbl[i].exp_irq);
      end

      // Raise the interrupt again, then reset with a read request in flight:
      // the read must not be returned and everything returns to reset values.
      drive(wr(4'h8, 32'h0000_0000, 1'b0, 1'b0), 1'b1);
      drive(idle(1'b0, 1'b0), 1'b1);
      check_irq("pre_reset_irq", 1'b1);
      drive(rd(4'h0, 32'h0, 1'b0), 1'b0);
      check_irq("mid_read_reset", 1'b0);
      drive(rd(4'h8, 32'hFFFF_FFFF, 1'b0), 1'b1);
      drive(rd(4'h0, 32'h0000_0000, 1'b0), 1'b1);
      drive(idle(1'b0, 1'b0), 1'b1);
      check_irq("post_reset", 1'b0);
      drive(idle(1'b0, 1'b0), 1'b1);
      drive(idle(1'b0, 1'b0), 1'b1);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rd_missing got %0d outstanding expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
